axil_slave_port: RTL and testbench
==================================

Name: axil_slave_port

Overview:
Parametrised AXI4-Lite slave endpoint that bridges the CPU-side AXI-Lite bus to a simple synchronous dual-port memory or register file. It has independent read and write channels, each with full VALID/READY handshaking. It supports byte strobes, a decoded address window with SLVERR on misses, and AW/W arrival in any order. It sits between the core's AXI-Lite master and the data memory / peripheral register blocks.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; legal values are 32 or 64
MEM_AW, 10, memory word-address width
BASE_ADDR, 32'h8000_0000, first byte address of the decoded window
WIN_BYTES, 4096, window size in bytes; must be a power of two and no larger than (2^MEM_AW)*(DATA_W/8)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset
AWADDR  in  ADDR_W  write address
AWPROT  in  3  write protection; ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte lane enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARPROT  in  3  read protection; ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
mem_ren  out  1  memory read enable
mem_raddr  out  MEM_AW  memory read word address
mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_ren
mem_wen  out  1  memory write enable
mem_waddr  out  MEM_AW  memory write word address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables

Behaviour:
- Reset is ARESETN: synchronous, active-low. Clock is ACLK.
- Reset values: all READY/VALID outputs 0, mem_ren 0, mem_wen 0, RDATA 0, RRESP 00, BRESP 00, both FSMs in IDLE.
- All READY and VALID outputs are registered. ARREADY, AWREADY and WREADY first rise on the first edge with ARESETN high.
- Address decode:
  - in_range = (ADDR - BASE_ADDR) < WIN_BYTES, computed unsigned at ADDR_W width.
  - Word index = (ADDR - BASE_ADDR) >> log2(DATA_W/8), truncated to MEM_AW bits.
  - Low byte-offset bits are ignored; unaligned accesses are treated as aligned.
- Read FSM states are R_IDLE, R_REQ, R_RESP.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch the address and drop ARREADY. If in range, go to R_REQ; otherwise go to R_RESP with RDATA=0, RRESP=10, RVALID=1.
  - R_REQ (exactly one cycle): mem_ren=1 and mem_raddr = latched index.
  - Next edge: RDATA <= mem_rdata, RRESP=00, RVALID=1, go to R_RESP.
  - R_RESP: hold RVALID, RDATA and RRESP stable until RVALID&RREADY. On that edge clear RVALID and set ARREADY=1 (back to R_IDLE).
  - Latency: AR handshake at edge N gives RVALID after edge N+2 (in range) or N+1 (miss). At most one read is outstanding.
- Write FSM states are W_IDLE, W_ISSUE, W_RESP.
  - W_IDLE: AWREADY=1 until an AW handshake, then 0 with address latched. WREADY=1 until a W handshake, then 0 with WDATA and WSTRB latched.
  - AW and W may complete in either order or on the same edge.
  - The edge on which both are held moves to W_ISSUE.
  - W_ISSUE (one cycle): mem_wen=1 with the latched addr/data/strb if in range; mem_wen=0 on a miss. Next edge: BVALID=1, BRESP=00 (hit) or 10 (miss), go to W_RESP.
  - W_RESP: hold BVALID and BRESP until BVALID&BREADY. On that edge, AWREADY=1, WREADY=1, back to W_IDLE.
  - WSTRB=0 still issues mem_wen with mem_wstrb=0 and responds OKAY.
- Read and write FSMs run fully concurrently. A same-cycle mem_ren/mem_wen to the same word is legal; the attached memory returns the pre-write data. The block does not arbitrate.
- VALID never depends on READY. Once asserted, VALID stays high until its handshake.
- BRESP and RRESP values are only 00 (OKAY) and 10 (SLVERR).

Test Plan:
- Reset held 3 cycles with ARVALID=1 -> ARREADY, AWREADY, WREADY and all VALIDs 0 during reset; ARREADY=1 after the first edge with ARESETN=1; mem_ren never pulses.
- Write 0x8000_0010 data 0xDEADBEEF WSTRB=4'b1111, AW two cycles before W, BREADY=1 -> one mem_wen pulse, mem_waddr=4, BRESP=00. Then read 0x8000_0010 -> RVALID two edges after AR handshake, RDATA=0xDEADBEEF, RRESP=00.
- AW and W on the same edge, WSTRB=4'b0100, WDATA=0x00AB0000 onto a word holding 0x11223344 -> subsequent read returns 0x11AB3344.
- Read 0x0000_0000 (outside window) -> no mem_ren, RVALID after one edge, RDATA=0, RRESP=10. Write 0x8000_1000 -> no mem_wen, BRESP=10.
- RREADY held low 5 cycles after RVALID -> RVALID and RDATA stable throughout, ARREADY stays 0, a new ARVALID is not accepted until the handshake completes.
- Concurrent read and write to word 8 in the same cycle -> read returns the old value; a following read returns the new value. Both BVALID and RVALID complete independently.

Source files
------------

// File: rtl/axil_slave_port_if.sv
// axil_slave_port_if: AXI4-Lite bus bundle between a master and axil_slave_port
interface axil_slave_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;
  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_slave_port.sv
// axil_slave_port: AXI4-Lite slave bridging to a synchronous dual-port memory with a decoded window
module axil_slave_port #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                WIN_BYTES = 4096
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axil_slave_port_if.slave    bus,
  output logic                mem_ren,
  output logic [MEM_AW-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_wen,
  output logic [MEM_AW-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);
  localparam int LB = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] WIN = ADDR_W'(WIN_BYTES);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;
  logic [ADDR_W-1:0]   ar_off_d, aw_off_d, ar_sh_d, aw_sh_d;
  logic                ar_hit_d, aw_hit_d;
  logic [MEM_AW-1:0]   ar_idx_d, aw_idx_d;
  logic                unused_ok;
  r_state_e            r_q;
  logic                arready_q, rpend_q, rhit_q, rvalid_q;
  logic [MEM_AW-1:0]   ridx_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  w_state_e            w_q;
  logic                awready_q, wready_q, awh_q, wh_q, whit_q, bvalid_q;
  logic                aw_fire, w_fire;
  logic [MEM_AW-1:0]   widx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          bresp_q;
  // Window decode: unsigned offset from base; byte-offset bits are dropped
  assign ar_off_d  = bus.ARADDR - BASE_ADDR;
  assign aw_off_d  = bus.AWADDR - BASE_ADDR;
  assign ar_hit_d  = ar_off_d < WIN;
  assign aw_hit_d  = aw_off_d < WIN;
  assign ar_sh_d   = ar_off_d >> LB;
  assign aw_sh_d   = aw_off_d >> LB;
  assign ar_idx_d  = ar_sh_d[MEM_AW-1:0];
  assign aw_idx_d  = aw_sh_d[MEM_AW-1:0];
  assign unused_ok = ^{bus.ARPROT, bus.AWPROT, ar_sh_d[ADDR_W-1:MEM_AW], aw_sh_d[ADDR_W-1:MEM_AW]};
  assign aw_fire   = awready_q && bus.AWVALID;
  assign w_fire    = wready_q && bus.WVALID;
  // Read channel: accept AR, one memory read cycle, then a response captured a cycle later
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_q       <= R_IDLE;
      arready_q <= 1'b0;
      rpend_q   <= 1'b0;
      rhit_q    <= 1'b0;
      ridx_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      case (r_q)
        R_IDLE:
          if (arready_q && bus.ARVALID) begin
            arready_q <= 1'b0;
            ridx_q    <= ar_idx_d;
            rhit_q    <= ar_hit_d;
            rpend_q   <= !ar_hit_d;
            r_q       <= ar_hit_d ? R_REQ : R_RESP;
          end else arready_q <= 1'b1;
        R_REQ: begin
          rpend_q <= 1'b1;
          r_q     <= R_RESP;
        end
        R_RESP:
          if (rpend_q) begin
            rpend_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rhit_q ? mem_rdata : '0;
            rresp_q  <= rhit_q ? 2'b00 : 2'b10;
          end else if (bus.RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_q       <= R_IDLE;
          end
        default: r_q <= R_IDLE;
      endcase
    end
  end
  // Write channel: collect AW and W in any order, issue one memory write, then respond
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_q       <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awh_q     <= 1'b0;
      wh_q      <= 1'b0;
      whit_q    <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      case (w_q)
        W_IDLE: begin
          awready_q <= !(awh_q || aw_fire);
          wready_q  <= !(wh_q || w_fire);
          if (aw_fire) begin
            awh_q  <= 1'b1;
            whit_q <= aw_hit_d;
            widx_q <= aw_idx_d;
          end
          if (w_fire) begin
            wh_q    <= 1'b1;
            wdata_q <= bus.WDATA;
            wstrb_q <= bus.WSTRB;
          end
          if ((awh_q || aw_fire) && (wh_q || w_fire)) w_q <= W_ISSUE;
        end
        W_ISSUE: begin
          bvalid_q <= 1'b1;
          bresp_q  <= whit_q ? 2'b00 : 2'b10;
          w_q      <= W_RESP;
        end
        W_RESP:
          if (bus.BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            awh_q     <= 1'b0;
            wh_q      <= 1'b0;
            w_q       <= W_IDLE;
          end
        default: w_q <= W_IDLE;
      endcase
    end
  end
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign mem_ren     = r_q == R_REQ;
  assign mem_raddr   = ridx_q;
  assign mem_wen     = (w_q == W_ISSUE) && whit_q;
  assign mem_waddr   = widx_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
endmodule

// File: tb/tb_axil_slave_port.sv
// tb_axil_slave_port: directed checks of axil_slave_port against a behavioural memory
module tb_axil_slave_port;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        mem_ren, mem_wen;
  logic [9:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  axil_slave_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axil_slave_port dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );
  always #5 ACLK = ~ACLK;
  // Synchronous memory: read returns pre-write contents, writes honour byte enables
  always @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[5] <= 32'h1122_3344;
      mem[8] <= 32'hCAFE_F00D;
    end else begin
      if (mem_ren) mem_rdata <= mem[mem_raddr];
      if (mem_wen) for (int b = 0; b < 4; b++) if (mem_wstrb[b]) mem[mem_waddr][8*b+:8] <= mem_wdata[8*b+:8];
    end
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int da, input int dw, input logic hit, input logic [9:0] idx);
    int n, w0;
    w0 = wen_cnt;
    chk("wr_ready", 32'({bus.AWREADY, bus.WREADY}), 32'h3);
    bus.AWADDR = addr;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    for (int c = 0; c <= (da > dw ? da : dw); c++) begin
      bus.AWVALID = (c == da);
      bus.WVALID  = (c == dw);
      tick();
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk("wen", 32'(mem_wen), 32'(hit));
    if (hit) begin
      chk("waddr", 32'(mem_waddr), 32'(idx));
      chk("wstrb", 32'(mem_wstrb), 32'(strb));
      chk("wdata", mem_wdata, data);
    end
    bus.BREADY = 1'b1;
    n = 0;
    while (!bus.BVALID && n < 8) begin
      tick();
      n++;
    end
    chk("b_latency", 32'(n), 1);
    chk("bresp", 32'(bus.BRESP), hit ? 32'h0 : 32'h2);
    tick();
    bus.BREADY = 1'b0;
    chk("b_done", 32'({bus.BVALID, bus.AWREADY, bus.WREADY}), 32'h3);
    chk("wen_count", 32'(wen_cnt - w0), hit ? 32'd1 : 32'd0);
  endtask
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp, input int hold);
    int   n, r0;
    logic hit;
    hit = (exp_resp == 2'b00);
    r0  = ren_cnt;
    chk("ar_ready", 32'(bus.ARREADY), 1);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    chk("ar_drop", 32'(bus.ARREADY), 0);
    chk("ren", 32'(mem_ren), 32'(hit));
    n = 0;
    while (!bus.RVALID && n < 8) begin
      tick();
      n++;
    end
    chk("r_latency", 32'(n), hit ? 32'd2 : 32'd1);
    chk("rdata", bus.RDATA, exp_data);
    chk("rresp", 32'(bus.RRESP), 32'(exp_resp));
    bus.ARADDR  = 32'h8000_0040;
    bus.ARVALID = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_vld_ardy", 32'({bus.RVALID, bus.ARREADY}), 32'h2);
      chk("hold_rdata", bus.RDATA, exp_data);
      chk("hold_rresp", 32'(bus.RRESP), 32'(exp_resp));
    end
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    chk("r_done", 32'({bus.RVALID, bus.ARREADY}), 32'h1);
    chk("ren_count", 32'(ren_cnt - r0), hit ? 32'd1 : 32'd0);
  endtask
  initial begin
    int          got_r, got_b;
    logic [31:0] crd;
    logic [1:0]  crr, cbr;
    ARESETN     = 1'b0;
    bus.AWADDR  = '0;
    bus.AWPROT  = 3'b000;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = 32'h8000_0000;
    bus.ARPROT  = 3'b000;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    repeat (3) begin
      tick();
      chk("reset_ready_valid", 32'({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID}), 0);
    end
    chk("reset_resp_data", 32'({bus.RRESP, bus.BRESP}) | bus.RDATA, 0);
    ARESETN     = 1'b1;
    bus.ARVALID = 1'b0;
    tick();
    chk("arready_up", 32'(bus.ARREADY), 1);
    chk("aw_w_ready_up", 32'({bus.AWREADY, bus.WREADY}), 32'h3);
    chk("no_ren_reset", 32'(ren_cnt), 0);
    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 2, 1'b1, 10'd4);
    rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
    wr(32'h8000_0014, 32'h00AB_0000, 4'b0100, 0, 0, 1'b1, 10'd5);
    rd(32'h8000_0014, 32'h11AB_3344, 2'b00, 0);
    wr(32'h8000_0014, 32'hFFFF_FFFF, 4'b0000, 1, 0, 1'b1, 10'd5);
    rd(32'h8000_0014, 32'h11AB_3344, 2'b00, 0);
    rd(32'h8000_0013, 32'hDEAD_BEEF, 2'b00, 0);
    rd(32'h0000_0000, 32'h0000_0000, 2'b10, 0);
    wr(32'h8000_1000, 32'h1234_5678, 4'b1111, 0, 0, 1'b0, 10'd0);
    rd(32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 0);
    wr(32'h8000_0FFC, 32'h0BAD_CAFE, 4'b1111, 1, 0, 1'b1, 10'd1023);
    rd(32'h8000_0FFC, 32'h0BAD_CAFE, 2'b00, 0);
    rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 5);
    bus.ARADDR  = 32'h8000_0020;
    bus.AWADDR  = 32'h8000_0020;
    bus.WDATA   = 32'h5A5A_5A5A;
    bus.WSTRB   = 4'b1111;
    bus.ARVALID = 1'b1;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    bus.BREADY  = 1'b1;
    bus.RREADY  = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk("conc_ren_wen", 32'({mem_ren, mem_wen}), 32'h3);
    chk("conc_addrs", 32'({mem_raddr, mem_waddr}), 32'({10'd8, 10'd8}));
    got_r = 0;
    got_b = 0;
    crd   = '0;
    crr   = 2'b11;
    cbr   = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.RVALID) begin
        got_r++;
        crd = bus.RDATA;
        crr = bus.RRESP;
      end
      if (bus.BVALID) begin
        got_b++;
        cbr = bus.BRESP;
      end
    end
    bus.BREADY = 1'b0;
    bus.RREADY = 1'b0;
    chk("conc_r_count", 32'(got_r), 1);
    chk("conc_b_count", 32'(got_b), 1);
    chk("conc_old_data", crd, 32'hCAFE_F00D);
    chk("conc_resps", 32'({crr, cbr}), 0);
    rd(32'h8000_0020, 32'h5A5A_5A5A, 2'b00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
